// File: rtl/hex_word_sender.sv
// Serialises a captured word as upper-case ASCII hex, MSB nibble first,
// optionally followed by CR LF, over a valid/ready character stream.
module hex_word_sender #(
  parameter int WORD_WIDTH     = 32,
  parameter bit APPEND_NEWLINE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic [7:0]            ascii_out,
  output logic                  ascii_valid,
  input  logic                  ascii_ready,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  // Handshakes: a word is taken on an edge with word_valid && word_ready;
  // a character is taken on an edge with ascii_valid && ascii_ready, and
  // ascii_out is held stable while ascii_valid is high and ascii_ready is low.

  localparam int NUM_NIBBLES = WORD_WIDTH / 4;
  localparam int CNT_W       = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_NIBBLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIGIT = 2'd1,
    ST_CR    = 2'd2,
    ST_LF    = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [7:0]            ascii_q, ascii_d;
  logic                  valid_q, valid_d;
  logic                  xfer;

  function automatic logic [3:0] nibble_at(input logic [WORD_WIDTH-1:0] w,
                                           input int idx);
    logic [WORD_WIDTH-1:0] shifted;
    shifted = w >> (4 * idx);
    return shifted[3:0];
  endfunction

  // 'A' - 10 = 8'h37, so letters share one adder with the digits.
  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

  assign xfer = valid_q & ascii_ready;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    ascii_d = ascii_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (word_valid) begin
          word_d  = word_in;
          cnt_d   = LAST_IDX;
          ascii_d = hex_char(nibble_at(word_in, NUM_NIBBLES - 1));
          valid_d = 1'b1;
          state_d = ST_DIGIT;
        end
      end
      ST_DIGIT: begin
        if (xfer) begin
          if (cnt_q == '0) begin
            if (APPEND_NEWLINE) begin
              ascii_d = 8'h0D;
              state_d = ST_CR;
            end else begin
              ascii_d = 8'h00;
              valid_d = 1'b0;
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d   = cnt_q - 1'b1;
            ascii_d = hex_char(nibble_at(word_q, int'(cnt_q) - 1));
          end
        end
      end
      ST_CR: begin
        if (xfer) begin
          ascii_d = 8'h0A;
          state_d = ST_LF;
        end
      end
      ST_LF: begin
        if (xfer) begin
          ascii_d = 8'h00;
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        ascii_d = 8'h00;
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      ascii_q <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      ascii_q <= ascii_d;
      valid_q <= valid_d;
    end
  end

  assign word_ready  = (state_q == ST_IDLE);
  assign busy        = ~word_ready;
  assign ascii_out   = ascii_q;
  assign ascii_valid = valid_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_hex_word_sender.sv
// Bench for hex_word_sender: three configurations driven in lock-step and
// checked every cycle against a character-queue model of the output stream.
module tb_hex_word_sender;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic        ascii_ready = 1'b0;

  logic       wr_a, av_a, bz_a, wr_b, av_b, bz_b, wr_c, av_c, bz_c;
  logic [7:0] ao_a, ao_b, ao_c;
  logic [1:0] st_a, st_b, st_c;

  int checks = 0;
  int failures = 0;
  bit rst_seen = 1'b0;

  // Pending characters per configuration; head is what ascii_out must show.
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic [7:0] exp_c[$];

  always #5 clk = ~clk;

  hex_word_sender #(.WORD_WIDTH(32), .APPEND_NEWLINE(1'b1)) dut_a (
    .clk(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid),
    .word_ready(wr_a), .ascii_out(ao_a), .ascii_valid(av_a),
    .ascii_ready(ascii_ready), .busy(bz_a), .dbg_state(st_a));

  hex_word_sender #(.WORD_WIDTH(32), .APPEND_NEWLINE(1'b0)) dut_b (
    .clk(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid),
    .word_ready(wr_b), .ascii_out(ao_b), .ascii_valid(av_b),
    .ascii_ready(ascii_ready), .busy(bz_b), .dbg_state(st_b));

  hex_word_sender #(.WORD_WIDTH(4), .APPEND_NEWLINE(1'b1)) dut_c (
    .clk(clk), .reset(reset), .word_in(word_in[3:0]), .word_valid(word_valid),
    .word_ready(wr_c), .ascii_out(ao_c), .ascii_valid(av_c),
    .ascii_ready(ascii_ready), .busy(bz_c), .dbg_state(st_c));

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_dut(input string tag, ref logic [7:0] q[$],
                           input logic wr, input logic av, input logic bz,
                           input logic [7:0] ao);
    check_eq({tag, "_word_ready"}, 32'(wr), 32'(q.size() == 0));
    check_eq({tag, "_ascii_valid"}, 32'(av), 32'(q.size() != 0));
    check_eq({tag, "_busy"}, 32'(bz), 32'(q.size() != 0));
    if (q.size() != 0) check_eq({tag, "_ascii_out"}, 32'(ao), 32'(q[0]));
    if (rst_seen) check_eq({tag, "_reset_ascii_out"}, 32'(ao), 32'h0);
  endtask

  // Model of one upcoming edge: an idle sender takes a word and queues its
  // text; a busy sender loses its head character when the sink is ready.
  task automatic step_model(ref logic [7:0] q[$], input int width,
                            input bit nl, input logic rdy, input logic vld,
                            input logic [31:0] w);
    int nib;
    if (q.size() == 0) begin
      if (vld) begin
        for (int k = width / 4 - 1; k >= 0; k--) begin
          nib = int'((w >> (4 * k)) & 32'hF);
          if (nib < 10) q.push_back(8'(48 + nib));
          else          q.push_back(8'(65 + nib - 10));
        end
        if (nl) begin
          q.push_back(8'h0D);
          q.push_back(8'h0A);
        end
      end
    end else if (rdy) begin
      void'(q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      exp_a.delete();
      exp_b.delete();
      exp_c.delete();
      rst_seen = 1'b1;
    end else begin
      check_dut("a", exp_a, wr_a, av_a, bz_a, ao_a);
      check_dut("b", exp_b, wr_b, av_b, bz_b, ao_b);
      check_dut("c", exp_c, wr_c, av_c, bz_c, ao_c);
      rst_seen = 1'b0;
      step_model(exp_a, 32, 1'b1, ascii_ready, word_valid, word_in);
      step_model(exp_b, 32, 1'b0, ascii_ready, word_valid, word_in);
      step_model(exp_c, 4, 1'b1, ascii_ready, word_valid, {28'h0, word_in[3:0]});
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    word_in = w;
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget = 60;
    ascii_ready = 1'b1;
    while (!(wr_a && wr_b && wr_c) && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check_eq("idle_timeout", {29'h0, wr_a, wr_b, wr_c}, 32'h7);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);

    // Full-speed stream with CR LF.
    ascii_ready = 1'b1;
    send_word(32'h1234ABCD);
    wait_idle();

    // All-zero then all-F words.
    send_word(32'h00000000);
    wait_idle();
    send_word(32'hFFFFFFFF);
    wait_idle();

    // First digit held under backpressure.
    ascii_ready = 1'b0;
    send_word(32'h1234ABCD);
    tick(5);
    ascii_ready = 1'b1;
    wait_idle();

    // Second word while busy must be ignored.
    word_in = 32'h1234ABCD;
    word_valid = 1'b1;
    tick();
    word_in = 32'hDEADBEEF;
    tick(2);
    word_valid = 1'b0;
    wait_idle();

    // Reset after three digits, then a fresh word.
    send_word(32'h1234ABCD);
    tick(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    send_word(32'h0000000A);
    wait_idle();

    // Single nibble values for the narrow sender.
    send_word(32'h00000009);
    wait_idle();

    // Random traffic, backpressure and occasional reset.
    for (int i = 0; i < 1500; i++) begin
      word_in = $urandom;
      word_valid = ($urandom_range(0, 3) == 0);
      ascii_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 80) == 0);
      tick();
    end
    reset = 1'b0;
    word_valid = 1'b0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
